// File: rtl/full_adder.sv
// Ripple-carry full adder (WIDTH=1 is the classic 1-bit cell) with a combinational
// result and a one-cycle registered copy qualified by a valid pulse.
module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_c,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic [WIDTH-1:0] sum_q,
  output logic             carry_q,
  output logic             valid_q
);

  // c_chain[i] is the carry into bit i; c_chain[WIDTH] is the carry-out of the MSB.
  logic [WIDTH:0] c_chain;

  assign c_chain[0] = in_c;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_bit
      logic ha0_sum;
      logic ha0_carry;
      logic ha1_carry;

      // Two half-adders per bit: operands first, then the incoming carry.
      assign ha0_sum      = in_a[i] ^ in_b[i];
      assign ha0_carry    = in_a[i] & in_b[i];
      assign sum[i]       = ha0_sum ^ c_chain[i];
      assign ha1_carry    = ha0_sum & c_chain[i];
      assign c_chain[i+1] = ha0_carry | ha1_carry;
    end
  endgenerate

  assign carry = c_chain[WIDTH];

  // Handshake: in_valid qualifies the inputs on a rising edge; valid_q is a one-cycle
  // pulse with no back-pressure, so the consumer must take sum_q/carry_q that cycle.
  // Reset wins over in_valid, so an input sampled together with reset is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
    end else if (in_valid) begin
      sum_q   <= sum;
      carry_q <= carry;
      valid_q <= 1'b1;
    end else begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_full_adder.sv
// Directed bench for full_adder at WIDTH 1, 8 and 16: truth table, registered latency,
// reset priority, multi-bit wrap, back-to-back stream and reset in mid-stream.
module tb_full_adder;

  logic clk;
  logic reset;

  logic       a1, b1, c1, v1;
  logic       sum1, carry1, sum_q1, carry_q1, valid_q1;

  logic [7:0] a8, b8;
  logic       c8, v8;
  logic [7:0] sum8, sum_q8;
  logic       carry8, carry_q8, valid_q8;

  logic [15:0] a16, b16;
  logic        c16, v16;
  logic [15:0] sum16, sum_q16;
  logic        carry16, carry_q16, valid_q16;

  int checks = 0;
  int errors = 0;

  logic [8:0] exp_q[$];

  full_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .reset(reset), .in_a(a1), .in_b(b1), .in_c(c1), .in_valid(v1),
    .sum(sum1), .carry(carry1), .sum_q(sum_q1), .carry_q(carry_q1), .valid_q(valid_q1)
  );

  full_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .in_a(a8), .in_b(b8), .in_c(c8), .in_valid(v8),
    .sum(sum8), .carry(carry8), .sum_q(sum_q8), .carry_q(carry_q8), .valid_q(valid_q8)
  );

  full_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .in_a(a16), .in_b(b16), .in_c(c16), .in_valid(v16),
    .sum(sum16), .carry(carry16), .sum_q(sum_q16), .carry_q(carry_q16), .valid_q(valid_q16)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // truth table rows: {a,b,c} and expected {carry,sum}
  logic [2:0] tt_in  [8];
  logic [1:0] tt_exp [8];

  // stream vectors: a, b, c and hand-computed {carry,sum}
  logic [7:0] st_a [3];
  logic [7:0] st_b [3];
  logic       st_c [3];
  logic [8:0] st_e [3];

  initial begin
    tt_in[0] = 3'b000; tt_exp[0] = 2'b00;
    tt_in[1] = 3'b100; tt_exp[1] = 2'b01;
    tt_in[2] = 3'b010; tt_exp[2] = 2'b01;
    tt_in[3] = 3'b110; tt_exp[3] = 2'b10;
    tt_in[4] = 3'b001; tt_exp[4] = 2'b01;
    tt_in[5] = 3'b101; tt_exp[5] = 2'b10;
    tt_in[6] = 3'b011; tt_exp[6] = 2'b10;
    tt_in[7] = 3'b111; tt_exp[7] = 2'b11;

    st_a[0] = 8'd10;  st_b[0] = 8'd20;  st_c[0] = 1'b0; st_e[0] = 9'd30;
    st_a[1] = 8'd200; st_b[1] = 8'd100; st_c[1] = 1'b0; st_e[1] = 9'd300;
    st_a[2] = 8'd255; st_b[2] = 8'd255; st_c[2] = 1'b1; st_e[2] = 9'd511;

    reset = 1'b1;
    a1 = 0; b1 = 0; c1 = 0; v1 = 0;
    a8 = 0; b8 = 0; c8 = 0; v8 = 0;
    a16 = 0; b16 = 0; c16 = 0; v16 = 0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_sum_q1",   sum_q1,   0);
    check("rst_carry_q1", carry_q1, 0);
    check("rst_valid_q1", valid_q1, 0);
    check("rst_valid_q8", valid_q8, 0);
    check("rst_sum_q16",  {carry_q16, sum_q16, valid_q16}, 0);

    // exhaustive truth table while reset is held
    for (int k = 0; k < 8; k++) begin
      {a1, b1, c1} = tt_in[k];
      #10;
      check($sformatf("tt_%03b", tt_in[k]), {carry1, sum1}, tt_exp[k]);
    end

    // registered latency
    @(negedge clk);
    reset = 1'b0;
    a1 = 1; b1 = 1; c1 = 1; v1 = 1;
    @(posedge clk); #1;
    v1 = 0;
    check("lat_sum_q",   sum_q1,   1);
    check("lat_carry_q", carry_q1, 1);
    check("lat_valid_q", valid_q1, 1);
    @(posedge clk); #1;
    check("hold_valid_q", valid_q1, 0);
    check("hold_sum_q",   sum_q1,   1);
    check("hold_carry_q", carry_q1, 1);

    // reset has priority over in_valid
    @(negedge clk);
    reset = 1'b1;
    a1 = 1; b1 = 1; c1 = 0; v1 = 1;
    @(posedge clk); #1;
    check("prio_sum_q",   sum_q1,   0);
    check("prio_carry_q", carry_q1, 0);
    check("prio_valid_q", valid_q1, 0);
    check("prio_comb",    {carry1, sum1}, 2'b10);
    @(negedge clk);
    reset = 1'b0;
    v1 = 0;

    // multi-bit wrap at WIDTH=16
    a16 = 16'hFFFF; b16 = 16'h0001; c16 = 0;
    #10;
    check("w16_wrap_sum",   sum16,   16'h0000);
    check("w16_wrap_carry", carry16, 1);
    a16 = 16'h1234; b16 = 16'h4321; c16 = 1;
    #10;
    check("w16_sum",   sum16,   16'h5556);
    check("w16_carry", carry16, 0);

    // back-to-back stream at WIDTH=8
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k > 0) begin
        check($sformatf("stream_valid_%0d", k - 1), valid_q8, 1);
        if (exp_q.size() == 0) check("stream_queue_empty", 1, 0);
        else check($sformatf("stream_result_%0d", k - 1), {carry_q8, sum_q8}, exp_q.pop_front());
      end
      if (k < 3) begin
        a8 = st_a[k]; b8 = st_b[k]; c8 = st_c[k]; v8 = 1;
        exp_q.push_back(st_e[k]);
      end else begin
        v8 = 0;
      end
    end
    @(negedge clk);
    check("stream_end_valid", valid_q8, 0);
    check("stream_queue_drained", exp_q.size(), 0);

    // reset in the middle of a valid stream
    @(negedge clk);
    a8 = 8'd1; b8 = 8'd2; c8 = 0; v8 = 1;
    exp_q.push_back(9'd3);
    @(negedge clk);
    check("mid_valid_0", valid_q8, 1);
    check("mid_result_0", {carry_q8, sum_q8}, exp_q.pop_front());
    a8 = 8'd4; b8 = 8'd5; c8 = 0; v8 = 1;
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", valid_q8, 0);
    check("mid_rst_result", {carry_q8, sum_q8}, 0);
    reset = 1'b0;
    a8 = 8'd6; b8 = 8'd7; c8 = 1; v8 = 1;
    exp_q.push_back(9'd14);
    @(negedge clk);
    v8 = 0;
    check("mid_resume_valid", valid_q8, 1);
    check("mid_resume_result", {carry_q8, sum_q8}, exp_q.pop_front());
    @(negedge clk);
    check("mid_end_valid", valid_q8, 0);
    check("mid_queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
